// File: rtl/pointwise_stream_tx.sv
// pointwise_stream_tx: transmitter side of the pointwise-conv input interface.
// It holds one feature map in a block-RAM buffer and streams it pixel-major,
// channel-minor. Each channel word is repeated on HOLD_CYCLES valid beats.
// An optional PIXEL_GAP idle cycles are inserted between pixels.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start        begin a run (taken only in IDLE or DONE)
//   wr_en/wr_addr/wr_data  buffer load port (taken only in IDLE or DONE, in range)
//   stall        consumer back-pressure; freezes the stream while high
//   data_out, channel_out, pixel_out, valid_out   registered stream beat
//   busy         state is STREAM or GAP
//   done         run finished; held until the next start
//   checksum     (only with POINTWISE_STREAM_TX_CHECKSUM_EN) mod-2^N sum of
//                the streamed words, one add per element, latched when done rises
//
// Optional feature macro: POINTWISE_STREAM_TX_CHECKSUM_EN
module pointwise_stream_tx #(
    parameter int unsigned N            = 16,
    parameter int unsigned IN_CHANNELS  = 40,
    parameter int unsigned FEATURE_SIZE = 14,
    parameter int unsigned HOLD_CYCLES  = 4,
    parameter int unsigned PIXEL_GAP    = 0
) (
    input  logic                                                    clk,
    input  logic                                                    rst,
    input  logic                                                    start,
    input  logic                                                    wr_en,
    input  logic [$clog2(IN_CHANNELS*FEATURE_SIZE*FEATURE_SIZE)-1:0] wr_addr,
    input  logic [N-1:0]                                            wr_data,
    input  logic                                                    stall,
    output logic [N-1:0]                                            data_out,
    output logic [$clog2(IN_CHANNELS)-1:0]                          channel_out,
    output logic [$clog2(FEATURE_SIZE*FEATURE_SIZE)-1:0]            pixel_out,
    output logic                                                    valid_out,
    output logic                                                    busy,
    output logic                                                    done
`ifdef POINTWISE_STREAM_TX_CHECKSUM_EN
    ,
    output logic [N-1:0]                                            checksum
`endif
);

    localparam int unsigned PIXELS   = FEATURE_SIZE * FEATURE_SIZE;
    localparam int unsigned DEPTH    = IN_CHANNELS * PIXELS;
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam int unsigned CW       = $clog2(IN_CHANNELS);
    localparam int unsigned PW       = $clog2(PIXELS);
    localparam int unsigned HW       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned GW       = (PIXEL_GAP > 1) ? $clog2(PIXEL_GAP) : 1;
    localparam int unsigned GAP_LAST = (PIXEL_GAP > 0) ? PIXEL_GAP - 1 : 0;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_GAP    = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [CW-1:0] ch_q, ch_d;
    logic [PW-1:0] pix_q, pix_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // read-issue stage (buffer read in flight)
    logic          issue_c;
    logic          issue_q, issue_d;
    logic [CW-1:0] issue_ch_q, issue_ch_d;
    logic [PW-1:0] issue_pix_q, issue_pix_d;
    logic [N-1:0]  rd_data_q;
    logic [AW-1:0] rd_addr_c;

    // output stage
    logic          valid_q, valid_d;
    logic [N-1:0]  data_q, data_d;
    logic [CW-1:0] channel_q, channel_d;
    logic [PW-1:0] pixel_q, pixel_d;

    logic          idle_or_done_c;
    logic          start_ok_c;
    logic          wr_ok_c;

    logic [N-1:0]  mem [DEPTH];

    assign idle_or_done_c = (state_q == S_IDLE) || (state_q == S_DONE);
    assign start_ok_c     = start && idle_or_done_c;
    assign wr_ok_c        = wr_en && idle_or_done_c && (32'(wr_addr) < DEPTH);
    assign rd_addr_c      = AW'(AW'(pix_q) * AW'(IN_CHANNELS) + AW'(ch_q));

    // Buffer: write port plus synchronous read, no reset so it maps to block RAM
    always_ff @(posedge clk) begin
        if (wr_ok_c) begin
            mem[wr_addr] <= wr_data;
        end
        if (issue_c) begin
            rd_data_q <= mem[rd_addr_c];
        end
    end

    // Sequencer: state, hold/channel/pixel/gap counters, busy/done
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        ch_d    = ch_q;
        pix_d   = pix_q;
        gap_d   = gap_q;
        done_d  = done_q;
        issue_c = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_STREAM;
                    hold_d  = '0;
                    ch_d    = '0;
                    pix_d   = '0;
                    gap_d   = '0;
                end
            end
            S_STREAM: begin
                if (!stall) begin
                    issue_c = 1'b1;
                    if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                        hold_d = '0;
                        if (ch_q == CW'(IN_CHANNELS - 1)) begin
                            ch_d = '0;
                            if (pix_q == PW'(PIXELS - 1)) begin
                                pix_d   = '0;
                                state_d = S_DONE;
                            end else begin
                                pix_d = pix_q + PW'(1);
                                if (PIXEL_GAP > 0) begin
                                    state_d = S_GAP;
                                    gap_d   = '0;
                                end
                            end
                        end else begin
                            ch_d = ch_q + CW'(1);
                        end
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
            end
            S_GAP: begin
                if (32'(gap_q) == GAP_LAST) begin
                    state_d = S_STREAM;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_STREAM) || (state_d == S_GAP);

        // done rises only once the last beat has left the output register
        if (start_ok_c) begin
            done_d = 1'b0;
        end else if ((state_q == S_DONE) && !issue_q) begin
            done_d = 1'b1;
        end
    end

    // Pipeline: read-issue stage then output register; outputs hold when idle
    always_comb begin
        issue_d     = issue_c;
        issue_ch_d  = issue_c ? ch_q : issue_ch_q;
        issue_pix_d = issue_c ? pix_q : issue_pix_q;

        valid_d   = issue_q;
        data_d    = issue_q ? rd_data_q : data_q;
        channel_d = issue_q ? issue_ch_q : channel_q;
        pixel_d   = issue_q ? issue_pix_q : pixel_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            ch_q        <= '0;
            pix_q       <= '0;
            gap_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            issue_q     <= 1'b0;
            issue_ch_q  <= '0;
            issue_pix_q <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            channel_q   <= '0;
            pixel_q     <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            ch_q        <= ch_d;
            pix_q       <= pix_d;
            gap_q       <= gap_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            issue_q     <= issue_d;
            issue_ch_q  <= issue_ch_d;
            issue_pix_q <= issue_pix_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            channel_q   <= channel_d;
            pixel_q     <= pixel_d;
        end
    end

    assign data_out    = data_q;
    assign channel_out = channel_q;
    assign pixel_out   = pixel_q;
    assign valid_out   = valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

`ifdef POINTWISE_STREAM_TX_CHECKSUM_EN
    // Checksum: one add per element (first hold beat), latched as done rises
    logic         issue_first_q, issue_first_d;
    logic [N-1:0] sum_q, sum_d;
    logic [N-1:0] checksum_q, checksum_d;

    always_comb begin
        issue_first_d = issue_c && (hold_q == '0);
        sum_d         = sum_q;
        checksum_d    = checksum_q;
        if (start_ok_c) begin
            sum_d      = '0;
            checksum_d = '0;
        end else begin
            if (issue_first_q) begin
                sum_d = sum_q + rd_data_q;
            end
            if (done_d && !done_q) begin
                checksum_d = sum_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_first_q <= 1'b0;
            sum_q         <= '0;
            checksum_q    <= '0;
        end else begin
            issue_first_q <= issue_first_d;
            sum_q         <= sum_d;
            checksum_q    <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_pointwise_stream_tx.sv
// Bench for pointwise_stream_tx: instance A (3 ch, 2x2, hold 2, gap 1) and
// instance B (3 ch, 2x2, hold 1, no gap). Directed scenarios, inline checks.
module tb_pointwise_stream_tx;

    logic        clk = 1'b0;
    logic        rst_a, rst_b, start_a, start_b, wr_en_a, wr_en_b, stall_a, stall_b;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;

    logic [15:0] data_a, data_b;
    logic [1:0]  ch_a, ch_b, pix_a, pix_b;
    logic        valid_a, valid_b, busy_a, busy_b, done_a, done_b;
`ifdef POINTWISE_STREAM_TX_CHECKSUM_EN
    logic [15:0] ck_a, ck_b;
`endif

    int total = 0;
    int bad   = 0;

    // capture buffers, one sample per negedge
    logic        a_v [64];
    logic [15:0] a_d [64];
    logic [1:0]  a_c [64];
    logic [1:0]  a_p [64];
    logic        a_busy [64];
    logic        a_done [64];
    logic        b_v [64];
    logic [15:0] b_d [64];
    logic [1:0]  b_c [64];
    logic [1:0]  b_p [64];
    logic        b_done [64];
    logic [15:0] b_ck [64];

    always #5 clk = ~clk;

    pointwise_stream_tx #(
        .N(16), .IN_CHANNELS(3), .FEATURE_SIZE(2), .HOLD_CYCLES(2), .PIXEL_GAP(1)
    ) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .wr_en(wr_en_a), .wr_addr(wr_addr),
        .wr_data(wr_data), .stall(stall_a), .data_out(data_a), .channel_out(ch_a),
        .pixel_out(pix_a), .valid_out(valid_a), .busy(busy_a), .done(done_a)
`ifdef POINTWISE_STREAM_TX_CHECKSUM_EN
        , .checksum(ck_a)
`endif
    );

    pointwise_stream_tx #(
        .N(16), .IN_CHANNELS(3), .FEATURE_SIZE(2), .HOLD_CYCLES(1), .PIXEL_GAP(0)
    ) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .wr_en(wr_en_b), .wr_addr(wr_addr),
        .wr_data(wr_data), .stall(stall_b), .data_out(data_b), .channel_out(ch_b),
        .pixel_out(pix_b), .valid_out(valid_b), .busy(busy_b), .done(done_b)
`ifdef POINTWISE_STREAM_TX_CHECKSUM_EN
        , .checksum(ck_b)
`endif
    );

    // expected k-th beat for a given hold count (3 channels per pixel)
    function automatic logic [15:0] exp_d(input int k, input int h);
        return 16'h0100 + 16'(k / h);
    endfunction
    function automatic logic [1:0] exp_c(input int k, input int h);
        return 2'((k / h) % 3);
    endfunction
    function automatic logic [1:0] exp_p(input int k, input int h);
        return 2'(k / (h * 3));
    endfunction

    task automatic load_buf(input bit sel, input int n);
        for (int a = 0; a < n; a++) begin
            wr_addr = 4'(a);
            wr_data = 16'h0100 + 16'(a);
            if (sel) wr_en_b = 1'b1; else wr_en_a = 1'b1;
            @(negedge clk);
        end
        wr_en_a = 1'b0;
        wr_en_b = 1'b0;
    endtask

    // pulse start on one DUT and record both DUTs for ncyc negedges;
    // wr_at = -1 writes alongside start, -2 never; restart_at re-pulses start
    task automatic cap(input int ncyc, input bit sel, input int st_from, input int st_len,
                       input int wr_at, input logic [3:0] wa, input logic [15:0] wd,
                       input int restart_at);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        if (wr_at == -1) begin
            wr_addr = wa;
            wr_data = wd;
            if (sel) wr_en_b = 1'b1; else wr_en_a = 1'b1;
        end
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            a_v[i] = valid_a; a_d[i] = data_a; a_c[i] = ch_a; a_p[i] = pix_a;
            a_busy[i] = busy_a; a_done[i] = done_a;
            b_v[i] = valid_b; b_d[i] = data_b; b_c[i] = ch_b; b_p[i] = pix_b;
            b_done[i] = done_b;
`ifdef POINTWISE_STREAM_TX_CHECKSUM_EN
            b_ck[i] = ck_b;
`else
            b_ck[i] = 16'h0000;
`endif
            start_a = 1'b0; start_b = 1'b0; wr_en_a = 1'b0; wr_en_b = 1'b0;
            stall_a = (i >= st_from) && (i < st_from + st_len);
            if (i == wr_at) begin
                wr_addr = wa;
                wr_data = wd;
                if (sel) wr_en_b = 1'b1; else wr_en_a = 1'b1;
            end
            if (i == restart_at) begin
                if (sel) start_b = 1'b1; else start_a = 1'b1;
            end
        end
        stall_a = 1'b0; wr_en_a = 1'b0; wr_en_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if (valid_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0 || data_a !== 16'h0
            || ch_a !== 2'd0 || pix_a !== 2'd0) begin
            bad++;
            $display("FAIL reset_a: got v=%b busy=%b done=%b d=%h c=%0d p=%0d want all 0",
                     valid_a, busy_a, done_a, data_a, ch_a, pix_a);
        end
        total++;
        if (valid_b !== 1'b0 || busy_b !== 1'b0 || done_b !== 1'b0) begin
            bad++;
            $display("FAIL reset_b: got v=%b busy=%b done=%b want 0 0 0", valid_b, busy_b, done_b);
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (valid_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: got v=%b busy=%b done=%b want 0 0 0",
                     valid_a, busy_a, done_a);
        end
    endtask

    task automatic test_stream();
        int nb, first, last, nz;
        int gp [3];
        gp = '{8, 15, 22};
        cap(40, 1'b0, -1, 0, -2, 4'd0, 16'h0, -1);
        nb = 0; first = -1; last = -1; nz = 0;
        for (int i = 0; i < 40; i++) begin
            if (a_v[i]) begin
                if (nb < 24) begin
                    total++;
                    if (a_d[i] !== exp_d(nb, 2) || a_c[i] !== exp_c(nb, 2) || a_p[i] !== exp_p(nb, 2)) begin
                        bad++;
                        $display("FAIL stream_beat%0d: got d=%h c=%0d p=%0d want d=%h c=%0d p=%0d",
                                 nb, a_d[i], a_c[i], a_p[i], exp_d(nb, 2), exp_c(nb, 2), exp_p(nb, 2));
                    end
                end
                if (first < 0) first = i;
                last = i;
                nb++;
            end else if (first >= 0) begin
                nz++;
            end
        end
        nz = nz - (39 - last);
        total++;
        if (nb != 24) begin bad++; $display("FAIL stream_count: got %0d want 24", nb); end
        total++;
        if (first != 2) begin bad++; $display("FAIL stream_latency: first valid at %0d want 2", first); end
        total++;
        if (last != 28) begin bad++; $display("FAIL stream_last: got %0d want 28", last); end
        total++;
        if (nz != 3) begin bad++; $display("FAIL stream_gaps: got %0d idle cycles want 3", nz); end
        for (int g = 0; g < 3; g++) begin
            total++;
            if (a_v[gp[g]] !== 1'b0) begin
                bad++;
                $display("FAIL stream_gap_pos%0d: valid=%b at %0d want 0", g, a_v[gp[g]], gp[g]);
            end
        end
        total++;
        if (a_busy[0] !== 1'b1) begin bad++; $display("FAIL stream_busy: got %b want 1", a_busy[0]); end
        total++;
        if (last < 0 || last > 38 || a_done[last] !== 1'b0 || a_done[last + 1] !== 1'b1) begin
            bad++;
            $display("FAIL stream_done: last=%0d done around last not 0->1", last);
        end
    endtask

    task automatic test_stall();
        int nb, last;
        cap(40, 1'b0, 2, 3, -2, 4'd0, 16'h0, -1);
        nb = 0; last = -1;
        for (int i = 0; i < 40; i++) begin
            if (a_v[i]) begin
                if (nb < 24) begin
                    total++;
                    if (a_d[i] !== exp_d(nb, 2) || a_c[i] !== exp_c(nb, 2) || a_p[i] !== exp_p(nb, 2)) begin
                        bad++;
                        $display("FAIL stall_beat%0d: got d=%h c=%0d p=%0d want d=%h c=%0d p=%0d",
                                 nb, a_d[i], a_c[i], a_p[i], exp_d(nb, 2), exp_c(nb, 2), exp_p(nb, 2));
                    end
                end
                last = i;
                nb++;
            end
        end
        total++;
        if (nb != 24) begin bad++; $display("FAIL stall_count: got %0d want 24", nb); end
        total++;
        if (a_v[3] !== 1'b1 || a_v[4] !== 1'b0 || a_v[5] !== 1'b0 || a_v[6] !== 1'b0) begin
            bad++;
            $display("FAIL stall_window: got v3..6=%b%b%b%b want 1000", a_v[3], a_v[4], a_v[5], a_v[6]);
        end
        total++;
        if (a_v[7] !== 1'b1 || a_d[7] !== 16'h0101 || a_c[7] !== 2'd1) begin
            bad++;
            $display("FAIL stall_resume: got v=%b d=%h c=%0d want 1 0101 1", a_v[7], a_d[7], a_c[7]);
        end
        total++;
        if (last != 31) begin bad++; $display("FAIL stall_last: got %0d want 31", last); end
        total++;
        if (a_done[32] !== 1'b1) begin bad++; $display("FAIL stall_done: got %b want 1", a_done[32]); end
    endtask

    task automatic test_reset_mid();
        int nb, first;
        bit hit;
        nb = 0; hit = 1'b0;
        start_a = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (valid_a) nb++;
            if (nb == 10) begin
                hit = 1'b1;
                break;
            end
        end
        total++;
        if (!hit) begin bad++; $display("FAIL rmid_reach: got %0d beats want 10", nb); end
        rst_a = 1'b1;
        @(negedge clk);
        total++;
        if (valid_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0 || data_a !== 16'h0) begin
            bad++;
            $display("FAIL rmid_outputs: got v=%b busy=%b done=%b d=%h want 0 0 0 0000",
                     valid_a, busy_a, done_a, data_a);
        end
        rst_a = 1'b0;
        @(negedge clk);
        cap(40, 1'b0, -1, 0, -2, 4'd0, 16'h0, -1);
        nb = 0; first = -1;
        for (int i = 0; i < 40; i++) begin
            if (a_v[i]) begin
                if (first < 0) first = i;
                if (nb < 24) begin
                    total++;
                    if (a_d[i] !== exp_d(nb, 2) || a_c[i] !== exp_c(nb, 2) || a_p[i] !== exp_p(nb, 2)) begin
                        bad++;
                        $display("FAIL rmid_beat%0d: got d=%h c=%0d p=%0d want d=%h c=%0d p=%0d",
                                 nb, a_d[i], a_c[i], a_p[i], exp_d(nb, 2), exp_c(nb, 2), exp_p(nb, 2));
                    end
                end
                nb++;
            end
        end
        total++;
        if (first != 2 || nb != 24) begin
            bad++;
            $display("FAIL rmid_replay: got first=%0d beats=%0d want 2 24", first, nb);
        end
    endtask

    task automatic test_write_busy();
        int nb;
        cap(40, 1'b0, -1, 0, 4, 4'd0, 16'hDEAD, -1);
        wr_addr = 4'd12;
        wr_data = 16'hBEEF;
        wr_en_a = 1'b1;
        @(negedge clk);
        wr_en_a = 1'b0;
        cap(40, 1'b0, -1, 0, -2, 4'd0, 16'h0, -1);
        total++;
        if (a_v[2] !== 1'b1 || a_d[2] !== 16'h0100 || a_c[2] !== 2'd0 || a_p[2] !== 2'd0) begin
            bad++;
            $display("FAIL wbusy_px0: got v=%b d=%h c=%0d p=%0d want 1 0100 0 0",
                     a_v[2], a_d[2], a_c[2], a_p[2]);
        end
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            if (a_v[i]) begin
                if (nb < 24) begin
                    total++;
                    if (a_d[i] !== exp_d(nb, 2)) begin
                        bad++;
                        $display("FAIL wbusy_beat%0d: got d=%h want d=%h", nb, a_d[i], exp_d(nb, 2));
                    end
                end
                nb++;
            end
        end
        total++;
        if (nb != 24) begin bad++; $display("FAIL wbusy_count: got %0d want 24", nb); end
    endtask

    task automatic test_back_to_back();
        int nb, first, last;
        // last word written on the same cycle as start
        load_buf(1'b1, 11);
        cap(20, 1'b1, -1, 0, -1, 4'd11, 16'h010B, 5);
        nb = 0; first = -1; last = -1;
        for (int i = 0; i < 20; i++) begin
            if (b_v[i]) begin
                if (nb < 12) begin
                    total++;
                    if (b_d[i] !== exp_d(nb, 1) || b_c[i] !== exp_c(nb, 1) || b_p[i] !== exp_p(nb, 1)) begin
                        bad++;
                        $display("FAIL b2b_beat%0d: got d=%h c=%0d p=%0d want d=%h c=%0d p=%0d",
                                 nb, b_d[i], b_c[i], b_p[i], exp_d(nb, 1), exp_c(nb, 1), exp_p(nb, 1));
                    end
                end
                if (first < 0) first = i;
                last = i;
                nb++;
            end
        end
        total++;
        if (nb != 12) begin bad++; $display("FAIL b2b_count: got %0d want 12", nb); end
        total++;
        if (first != 2) begin bad++; $display("FAIL b2b_latency: got %0d want 2", first); end
        total++;
        if (last != 13) begin bad++; $display("FAIL b2b_nogap: last beat at %0d want 13", last); end
        total++;
        if (b_done[13] !== 1'b0 || b_done[14] !== 1'b1) begin
            bad++;
            $display("FAIL b2b_done: got %b%b want 01", b_done[13], b_done[14]);
        end
`ifdef POINTWISE_STREAM_TX_CHECKSUM_EN
        total++;
        if (b_ck[14] !== 16'h0C42) begin
            bad++;
            $display("FAIL b2b_checksum: got %h want 0c42", b_ck[14]);
        end
`endif
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        wr_en_a = 1'b0; wr_en_b = 1'b0;
        stall_a = 1'b0; stall_b = 1'b0;
        wr_addr = 4'd0; wr_data = 16'h0;
        test_reset();
        load_buf(1'b0, 12);
        test_stream();
        test_stall();
        test_reset_mid();
        test_write_busy();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1);
    end

endmodule

// File: doc/pointwise_stream_tx.md
Name: pointwise_stream_tx

Overview:
- Transmitter side of the pointwise-conv input interface: holds one feature map in a block-RAM buffer and streams it pixel-major, channel-minor as {data, channel, valid} beats.
- Sits between the depthwise/activation output buffer and the pointwise convolution. Upstream loads the map through a simple write port.
- Each channel word is repeated on HOLD_CYCLES consecutive valid beats, so a sequential single-multiplier consumer can walk its output-channel groups.
- An optional idle gap is inserted between pixels so the consumer can detect pixel boundaries.

Parameters:
- N, 16, data width (Q-format agnostic; data passes through unchanged).
- IN_CHANNELS, 40, channels per pixel (>=2).
- FEATURE_SIZE, 14, map is FEATURE_SIZE x FEATURE_SIZE (>=2).
- HOLD_CYCLES, 4, valid beats per channel word (>=1).
- PIXEL_GAP, 0, idle cycles (valid_out=0) inserted after each pixel except the last.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin streaming; sampled only in IDLE or DONE
- wr_en  in  1  buffer write strobe
- wr_addr  in  $clog2(IN_CHANNELS*FEATURE_SIZE*FEATURE_SIZE)  address = pixel*IN_CHANNELS + channel
- wr_data  in  N  word to write
- stall  in  1  consumer back-pressure; freezes stream
- data_out  out  N  streamed word
- channel_out  out  $clog2(IN_CHANNELS)  channel index of data_out
- pixel_out  out  $clog2(FEATURE_SIZE*FEATURE_SIZE)  pixel index of data_out
- valid_out  out  1  beat valid
- busy  out  1  high in STREAM or GAP
- done  out  1  high in DONE until next start

Behaviour:
- Reset (synchronous): state=IDLE, all outputs 0, all counters 0. Buffer contents are not cleared. Reset asserted mid-stream aborts; the outputs are 0 on the edge reset is sampled.
- Writes: accepted when wr_en=1, state is IDLE or DONE, and wr_addr < IN_CHANNELS*FEATURE_SIZE^2.
  - Writes while busy are ignored.
  - Out-of-range addresses are ignored.
- States: IDLE, STREAM, GAP, DONE.
  - IDLE/DONE --start--> STREAM. Counters are cleared and done drops on that edge.
  - start while busy is ignored.
  - start and wr_en on the same cycle in IDLE: the write completes and streaming starts.
- Read: a synchronous 1-cycle buffer read. All outputs are registered.
  - Rule: if state==STREAM and stall==0 at edge t, then at t+1 valid_out=1 and data_out/channel_out/pixel_out are the current (pixel, ch) word. Otherwise valid_out=0 at t+1, and data/channel/pixel hold their last values.
  - Latency: start sampled at edge 0; first valid_out=1 after edge 2 (state enters STREAM at edge 0+1 and issues the read at edge 1).
  - A stall sampled at edge t removes the beat at t+1. No hold count is consumed, counters are frozen, and the same element resumes after stall drops. Stall in GAP/IDLE/DONE has no effect.
- Counters: hold_cnt counts 0..HOLD_CYCLES-1 per non-stalled STREAM cycle.
  - On wrap, ch increments.
  - On ch wrap (IN_CHANNELS-1 -> 0), pixel increments.
  - At pixel wrap, if PIXEL_GAP>0 and this is not the last pixel, go to GAP for exactly PIXEL_GAP cycles, then back to STREAM.
  - After the final beat (pixel FS^2-1, ch IN_CHANNELS-1, hold HOLD_CYCLES-1), go to DONE. done=1 is visible on the cycle after the last valid_out=1 cycle.
- Total valid beats per run = FEATURE_SIZE^2 * IN_CHANNELS * HOLD_CYCLES, regardless of stall pattern.
- The stream is gap-free within a pixel when stall=0.
- busy = (state==STREAM || state==GAP), registered alongside the state.

Optional Feature:
- Macro POINTWISE_STREAM_TX_CHECKSUM_EN.
- Defined: adds output checksum [N-1:0]. An internal register clears on start and adds data_out (mod 2^N) once per element, i.e. only on the first hold beat. checksum is updated when done rises and holds until the next start. Reset value is 0.
- Undefined: no checksum port and no accumulator logic.

Test Plan:
- All tests use IN_CHANNELS=3, FEATURE_SIZE=2, HOLD_CYCLES=2, PIXEL_GAP=1 unless stated.
- Load buffer[a]=0x0100+a (a=0..11), pulse start, stall=0.
  - Expect 24 valid beats: channel pattern 0,0,1,1,2,2 per pixel, data 0x0100..0x010B each twice, pixel_out 0..3.
  - Exactly 1 valid_out=0 cycle between pixels; done=1 one cycle after the last beat.
- Stall: hold stall=1 for 3 cycles starting at the third beat (ch1, first hold).
  - Expect valid_out=0 for 3 cycles, then resume with ch1 first hold.
  - Total beats still 24; beat sequence identical to the unstalled run.
- Reset mid-stream: assert rst at beat 10.
  - Next cycle: valid_out=0, busy=0, done=0.
  - A new start replays from pixel 0, ch 0; buffer contents are retained.
- Write-while-busy: wr_en with wr_addr=0, wr_data=0xDEAD during STREAM.
  - Rerun after done: pixel0/ch0 still 0x0100.
  - Write to wr_addr=12 (out of range) in IDLE is ignored.
- HOLD_CYCLES=1, PIXEL_GAP=0: expect 12 back-to-back beats with no gaps.
  - First valid_out after 2 edges from start; start asserted while busy is ignored.
  - With POINTWISE_STREAM_TX_CHECKSUM_EN: checksum=0x0C42 at done.
